// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one dram_ctrl port between m0 (icache) and m1 (dcache), one transaction at a time.
// Define DRAM_ARB_RR_EN for round-robin arbitration; by default m1 has fixed priority over m0.
module dram_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [2:0]        m0_rd_ctrl,
  input  logic [2:0]        m0_wr_ctrl,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_din,
  output logic [DATA_W-1:0] m0_dout,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [2:0]        m1_rd_ctrl,
  input  logic [2:0]        m1_wr_ctrl,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_din,
  output logic [DATA_W-1:0] m1_dout,
  output logic              m1_ack,
  output logic [1:0]        gnt,
  output logic [2:0]        dram_rd_ctrl,
  output logic [2:0]        dram_wr_ctrl,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_din,
  input  logic [DATA_W-1:0] dram_dout,
  input  logic              dram_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;   // 1: m1 owned the most recent transaction
  logic              null_q, null_d;   // latched command has neither read nor write
  logic [2:0]        rd_q, rd_d;
  logic [2:0]        wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] dout0_q, dout0_d;
  logic [DATA_W-1:0] dout1_q, dout1_d;

  logic              win_s;            // 1: m1 wins this IDLE cycle
  logic [2:0]        sel_rd_s;
  logic [2:0]        sel_wr_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_din_s;
  logic              sel_null_s;
  logic [DATA_W-1:0] capture_s;

  // Arbitration between the two requesters
  always_comb begin
    win_s = 1'b0;
`ifdef DRAM_ARB_RR_EN
    if (m0_req && m1_req) begin
      win_s = ~last_q;
    end else begin
      win_s = m1_req;
    end
`else
    win_s = m1_req;
`endif
  end

  // Winner's command, sanitised so a write always beats a simultaneous read
  always_comb begin
    sel_wr_s   = win_s ? m1_wr_ctrl : m0_wr_ctrl;
    sel_rd_s   = 3'd0;
    if (sel_wr_s == 3'd0) begin
      sel_rd_s = win_s ? m1_rd_ctrl : m0_rd_ctrl;
    end else begin
      sel_rd_s = 3'd0;
    end
    sel_null_s = (sel_rd_s == 3'd0) && (sel_wr_s == 3'd0);
    sel_addr_s = '0;
    sel_din_s  = '0;
    if (!sel_null_s) begin
      sel_addr_s = win_s ? m1_addr : m0_addr;
      sel_din_s  = win_s ? m1_din  : m0_din;
    end else begin
      sel_addr_s = '0;
      sel_din_s  = '0;
    end
    capture_s  = (rd_q != 3'd0) ? dram_dout : '0;
  end

  // Next-state and registered-output logic of the transaction FSM
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    null_d  = null_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ack_d   = 2'b00;
    dout0_d = '0;
    dout1_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ST_BUSY;
          gnt_d   = win_s ? 2'b10 : 2'b01;
          rd_d    = sel_rd_s;
          wr_d    = sel_wr_s;
          addr_d  = sel_addr_s;
          din_d   = sel_din_s;
          null_d  = sel_null_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // An empty command completes on its own without touching dram
        if (dram_done || null_q) begin
          state_d = ST_RESP;
          rd_d    = 3'd0;
          wr_d    = 3'd0;
          addr_d  = '0;
          din_d   = '0;
          ack_d   = gnt_q;
          dout0_d = gnt_q[0] ? capture_s : '0;
          dout1_d = gnt_q[1] ? capture_s : '0;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        last_d  = gnt_q[1];
        null_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        null_d  = 1'b0;
        rd_d    = 3'd0;
        wr_d    = 3'd0;
        addr_d  = '0;
        din_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      null_q  <= 1'b0;
      rd_q    <= 3'd0;
      wr_q    <= 3'd0;
      addr_q  <= '0;
      din_q   <= '0;
      ack_q   <= 2'b00;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      null_q  <= null_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ack_q   <= ack_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  assign gnt          = gnt_q;
  assign m0_ack       = ack_q[0];
  assign m1_ack       = ack_q[1];
  assign m0_dout      = dout0_q;
  assign m1_dout      = dout1_q;
  assign dram_rd_ctrl = rd_q;
  assign dram_wr_ctrl = wr_q;
  assign dram_addr    = addr_q;
  assign dram_din     = din_q;

endmodule
